// File: rtl/apb_seq_pkg.sv
// rtl/apb_seq_pkg.sv - shared state encoding and command layout helpers for the APB command sequencer
// Contents:
//   seq_state_t / ST_*  : sequencer FSM state type and encodings
//   cmd_w()             : packed command width = 1 + ADDR_W + DATA_W
//   cmd_wr_bit()        : bit index of the write flag inside a packed command
//   cmd_addr_lsb()      : LSB of the address field inside a packed command
//   CMD_DATA_LSB        : LSB of the data field inside a packed command
//   tmo_cnt_w()         : timeout counter width = $clog2(TIMEOUT) + 1
package apb_seq_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 3'd0;
  localparam seq_state_t ST_ISSUE = 3'd1;
  localparam seq_state_t ST_WAIT  = 3'd2;
  localparam seq_state_t ST_CAPT  = 3'd3;
  localparam seq_state_t ST_RESP  = 3'd4;

  localparam int CMD_DATA_LSB = 0;

  // Packed command layout, MSB to LSB: {write, addr, data}
  function automatic int cmd_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int cmd_wr_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int cmd_addr_lsb(input int data_w);
    return data_w;
  endfunction

  // One spare bit so the counter can hold TIMEOUT itself
  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/apb_cmd_sequencer_fifo.sv
// rtl/apb_cmd_sequencer_fifo.sv - registered synchronous FIFO holding queued commands
// Module: sync_fifo
// Ports:
//   clk, rst              : clock, synchronous active-high reset (flushes the FIFO)
//   push, push_data       : write request and data; ignored while full
//   pop, pop_data         : read request and head-of-queue data; ignored while empty
//   count                 : current occupancy, 0..DEPTH
//   full, empty           : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  // Full refuses the push even when a pop happens in the same cycle
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// rtl/apb_cmd_sequencer.sv - queues client read/write commands and issues them one at a time to the APB top
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready               : client request handshake
//   cmd_write, cmd_addr, cmd_wdata    : request fields (wdata ignored on reads)
//   rsp_valid/rsp_ready               : response handshake, response held until accepted
//   rsp_write, rsp_rdata, rsp_err     : response fields (rdata 0 for writes and timeouts)
//   start_valid                       : one-cycle start pulse to the top
//   st_wr_rd, wr_data, wr_addr, rd_addr : access fields to the top, 0 outside an access
//   rd_data, xfer_done                : read data and completion pulse from the top
//   busy                              : an access or response is in progress
//   count                             : command FIFO occupancy
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     start_valid,
  output logic                     st_wr_rd,
  output logic [DATA_W-1:0]        wr_data,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  input  logic                     xfer_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CMD_W    = cmd_w(ADDR_W, DATA_W);
  localparam int WR_BIT   = cmd_wr_bit(ADDR_W, DATA_W);
  localparam int ADDR_LSB = cmd_addr_lsb(DATA_W);
  localparam int TMO_W    = tmo_cnt_w(TIMEOUT);

  seq_state_t        state;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              iss_write;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_data;

  logic              fifo_push;
  logic              fifo_pop;
  logic [CMD_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drive_on;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  // Pop only from IDLE, so at most one access is ever outstanding
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({cmd_write, cmd_addr, cmd_wdata}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      iss_write <= 1'b0;
      iss_addr  <= '0;
      iss_data  <= '0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            iss_write <= fifo_head[WR_BIT];
            iss_addr  <= fifo_head[ADDR_LSB +: ADDR_W];
            iss_data  <= fifo_head[CMD_DATA_LSB +: DATA_W];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion on the expiry cycle still wins over the timeout
          if (xfer_done) begin
            state <= ST_CAPT;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            rsp_write <= iss_write;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_CAPT: begin
          // The top presents read data one cycle after xfer_done
          rsp_write <= iss_write;
          rsp_err   <= 1'b0;
          rsp_rdata <= iss_write ? '0 : rd_data;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = (state != ST_IDLE);
  assign start_valid = (state == ST_ISSUE);
  assign rsp_valid   = (state == ST_RESP);

  // Access fields are presented from ISSUE through CAPT and forced to 0 otherwise
  assign drive_on = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_CAPT);
  assign st_wr_rd = drive_on && iss_write;
  assign wr_addr  = (drive_on && iss_write)  ? iss_addr : '0;
  assign wr_data  = (drive_on && iss_write)  ? iss_data : '0;
  assign rd_addr  = (drive_on && !iss_write) ? iss_addr : '0;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb/tb_apb_cmd_sequencer.sv - self-checking bench for apb_cmd_sequencer with a transaction-level model
module tb_apb_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              start_valid;
  logic              st_wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              xfer_done;
  logic              busy;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  apb_cmd_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .start_valid(start_valid), .st_wr_rd(st_wr_rd), .wr_data(wr_data),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .xfer_done(xfer_done), .busy(busy), .count(count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: a queue of accepted commands plus the timeline
  // (start cycle, response cycle, capture cycle) of the single access in flight.
  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } cmd_t;

  cmd_t              mq[$];
  bit                model_en = 1'b0;
  bit                m_have = 1'b0;
  cmd_t              m_cmd;
  int                m_start = -1;
  int                m_resp = -1;
  int                m_capt = -1;
  bit                m_err = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  int                cyc = 0;

  int                sz;
  bit                e_sv;
  bit                e_rv;
  bit                fon;
  bit                was_have;

  always @(negedge clk) begin
    if (model_en) begin
      sz   = mq.size();
      e_sv = m_have && (cyc == m_start);
      e_rv = m_have && (m_resp >= 0) && (cyc >= m_resp);
      fon  = m_have && !e_rv;

      chk("cmd_ready", cmd_ready, sz < DEPTH);
      chk("count", count, sz);
      chk("busy", busy, m_have);
      chk("start_valid", start_valid, e_sv);
      chk("st_wr_rd", st_wr_rd, fon && m_cmd.w);
      chk("wr_addr", wr_addr, (fon && m_cmd.w) ? m_cmd.a : '0);
      chk("wr_data", wr_data, (fon && m_cmd.w) ? m_cmd.d : '0);
      chk("rd_addr", rd_addr, (fon && !m_cmd.w) ? m_cmd.a : '0);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        chk("rsp_write", rsp_write, m_cmd.w);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_rdata", rsp_rdata, m_rdata);
      end

      if (rst) begin
        mq.delete();
        m_have = 1'b0;
      end else begin
        was_have = m_have;
        if (m_have && m_resp < 0 && xfer_done && cyc > m_start) begin
          m_resp = cyc + 2;
          m_capt = cyc + 1;
          m_err  = 1'b0;
        end else if (m_have && m_resp < 0 && cyc == m_start + TIMEOUT) begin
          m_resp  = cyc + 1;
          m_capt  = -1;
          m_err   = 1'b1;
          m_rdata = '0;
        end
        if (m_have && cyc == m_capt) begin
          m_rdata = m_cmd.w ? '0 : rd_data;
        end
        if (e_rv && rsp_ready) begin
          m_have = 1'b0;
        end
        if (!was_have && sz > 0) begin
          m_cmd   = mq.pop_front();
          m_have  = 1'b1;
          m_start = cyc + 1;
          m_resp  = -1;
          m_capt  = -1;
        end
        if (cmd_valid && sz < DEPTH) begin
          mq.push_back('{cmd_write, cmd_addr, cmd_wdata});
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Bounded waits: leave the caller just after the negedge of the cycle where the signal is high
  task automatic wait_start(input string nm, input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (start_valid !== 1'b1 && n < max) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk(nm, start_valid, 1'b1);
  endtask

  task automatic wait_rsp(input string nm, input int max, output int n);
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < max) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk(nm, rsp_valid, 1'b1);
  endtask

  int n;
  int nrsp;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; rd_data = '0; xfer_done = 1'b0;
    tick();
    tick();
    model_en = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // 1: write, start at T+2, done 3 cycles after start
    push_cmd(1'b1, 32'h10, 32'hDEADBEEF);
    tick(); cmd_valid = 1'b0;
    @(negedge clk); chk("t1_no_start_t1", start_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_start", start_valid, 1'b1);
    chk("t1_st_wr_rd", st_wr_rd, 1'b1);
    chk("t1_wr_addr", wr_addr, 32'h10);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);
    chk("t1_rd_addr", rd_addr, 0);
    tick(); tick(); tick(); xfer_done = 1'b1;
    tick(); xfer_done = 1'b0;
    @(negedge clk); chk("t1_no_rsp_capt", rsp_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_write", rsp_write, 1'b1);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata, 0);
    tick(); rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;

    // 2: read, data arrives the cycle after xfer_done
    push_cmd(1'b0, 32'h10, 32'h55);
    tick(); cmd_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_start", start_valid, 1'b1);
    chk("t2_rd_addr", rd_addr, 32'h10);
    chk("t2_wr_addr", wr_addr, 0);
    chk("t2_wr_data", wr_data, 0);
    tick(); tick(); xfer_done = 1'b1;
    tick(); xfer_done = 1'b0; rd_data = 32'hDEADBEEF;
    tick(); rd_data = '0;
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t2_rsp_write", rsp_write, 1'b0);
    tick(); rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0;

    // 3: five pushes against a stalled response, then release
    xfer_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b1, 32'h100 + 32'(i * 4), 32'(i));
      n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 20) begin
        tick();
        @(negedge clk);
        n++;
      end
      chk("t3_push_accept", cmd_ready, 1'b1);
      tick();
    end
    push_cmd(1'b1, 32'h200, 32'h6);
    @(negedge clk);
    chk("t3_full_count", count, 4);
    chk("t3_full_ready", cmd_ready, 1'b0);
    tick(); tick();
    @(negedge clk);
    chk("t3_refused_count", count, 4);
    tick();
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) nrsp++;
      tick();
    end
    chk("t3_responses", nrsp, 5);
    rsp_ready = 1'b0; xfer_done = 1'b0;

    // 4: timeout on a read, then the queued write completes normally
    push_cmd(1'b0, 32'h20, 32'h0);
    tick(); push_cmd(1'b1, 32'h24, 32'hA5A5);
    tick(); cmd_valid = 1'b0;
    wait_start("t4_start", 10);
    tick();
    wait_rsp("t4_rsp", 40, n);
    chk("t4_latency", n, 16);
    chk("t4_rsp_err", rsp_err, 1'b1);
    chk("t4_rsp_rdata", rsp_rdata, 0);
    tick(); rsp_ready = 1'b1; xfer_done = 1'b1;
    tick(); rsp_ready = 1'b0;
    wait_rsp("t4_next_rsp", 20, n);
    chk("t4_next_err", rsp_err, 1'b0);
    chk("t4_next_write", rsp_write, 1'b1);
    tick(); rsp_ready = 1'b1;
    tick(); rsp_ready = 1'b0; xfer_done = 1'b0;
    tick();

    // 5: reset during WAIT with two commands queued
    push_cmd(1'b1, 32'h30, 32'h1);
    tick(); push_cmd(1'b0, 32'h34, 32'h2);
    tick(); push_cmd(1'b1, 32'h38, 32'h3);
    tick(); cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_count_before", count, 2);
    chk("t5_busy_before", busy, 1'b1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; xfer_done = 1'b1;
    @(negedge clk);
    chk("t5_count", count, 0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_start", start_valid, 1'b0);
    chk("t5_cmd_ready", cmd_ready, 1'b1);
    tick(); xfer_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 1'b0);
      tick();
    end

    // 6: response stalled for 10 cycles
    xfer_done = 1'b1; rd_data = 32'h12345678;
    push_cmd(1'b0, 32'h40, 32'h0);
    tick(); push_cmd(1'b1, 32'h44, 32'h9);
    tick(); cmd_valid = 1'b0;
    wait_rsp("t6_rsp", 20, n);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("t6_rsp_valid", rsp_valid, 1'b1);
      chk("t6_rsp_rdata", rsp_rdata, 32'h12345678);
      chk("t6_rsp_write", rsp_write, 1'b0);
      chk("t6_no_start", start_valid, 1'b0);
    end
    tick(); rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rsp_ready = 1'b0; xfer_done = 1'b0; rd_data = '0;

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom % 3) != 0;
      cmd_write = 1'($urandom % 2);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      rsp_ready = ($urandom % 2) != 0;
      xfer_done = ($urandom % 8) == 0;
      rd_data   = $urandom;
      rst       = ($urandom % 500) == 0;
      tick();
    end
    cmd_valid = 1'b0; rst = 1'b0; rsp_ready = 1'b1; xfer_done = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    @(negedge clk);
    chk("drain_count", count, 0);
    chk("drain_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
